// File: rtl/layer_sequencer_if.sv
// Bundle of host, descriptor-SRAM and control-register signals around layer_sequencer.
// The master modport is the sequencer side; slave is the environment side.
interface layer_sequencer_if #(
  parameter int DESC_ADDR_BITS = 6
);
  logic                      start;
  logic [4:0]                num_layers;
  logic                      busy;
  logic                      all_done;
  logic [3:0]                layer_idx;
  logic                      desc_re;
  logic [DESC_ADDR_BITS-1:0] desc_addr;
  logic [31:0]               desc_rdata;
  logic                      ctrl_reg_w_en;
  logic [1:0]                ctrl_reg_wsel;
  logic [31:0]               ctrl_reg_wdata;
  logic                      dla_done;

  modport master (
    input  start, num_layers, desc_rdata, dla_done,
    output busy, all_done, layer_idx, desc_re, desc_addr,
           ctrl_reg_w_en, ctrl_reg_wsel, ctrl_reg_wdata
  );

  modport slave (
    output start, num_layers, desc_rdata, dla_done,
    input  busy, all_done, layer_idx, desc_re, desc_addr,
           ctrl_reg_w_en, ctrl_reg_wsel, ctrl_reg_wdata
  );
endinterface

// File: rtl/layer_sequencer.sv
// Fetches four descriptor words per layer into the DLA control registers, starts the
// accelerator via op_config bit0, waits for done, clears the start bit and moves on.
module layer_sequencer #(
  parameter int NUM_LAYERS_MAX = 16,
  parameter int DESC_ADDR_BITS = 6
) (
  input logic                clk,
  input logic                rst,
  layer_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAIT_DONE, CLEAR, WAIT_IDLE, FINISH
  } state_t;

  state_t                    state_q;
  logic [4:0]                n_q;
  logic [1:0]                k_q;
  logic [3:0]                idx_q;
  logic [31:0]               opcfg_q;
  logic [31:0]               wdata_q;
  logic                      busy_q;
  logic                      all_done_q;
  logic                      desc_re_q;
  logic [DESC_ADDR_BITS-1:0] addr_q;
  logic                      w_en_q;
  logic [1:0]                wsel_q;

  logic [4:0]                n_clamped;
  logic [31:0]               load_wdata;
  logic                      last_layer;

  function automatic logic [DESC_ADDR_BITS-1:0] word_addr(input logic [3:0] idx,
                                                           input logic [1:0] k);
    logic [5:0] a;
    a = {idx, k};
    return DESC_ADDR_BITS'(a);
  endfunction

  assign n_clamped  = (bus.num_layers > 5'(NUM_LAYERS_MAX)) ? 5'(NUM_LAYERS_MAX)
                                                             : bus.num_layers;
  // SRAM data lands in the LOAD cycle itself, so it is the one input routed straight out.
  assign load_wdata = {bus.desc_rdata[31:1], bus.desc_rdata[0] | (k_q == 2'd3)};
  assign last_layer = ({1'b0, idx_q} + 5'd1) == n_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      idx_q      <= '0;
      opcfg_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      desc_re_q  <= 1'b0;
      addr_q     <= '0;
      w_en_q     <= 1'b0;
      wsel_q     <= '0;
    end else begin
      all_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The cycle carrying all_done is still part of the finished run.
          if (bus.start && !all_done_q) begin
            busy_q <= 1'b1;
            n_q    <= n_clamped;
            if (n_clamped == 5'd0) begin
              state_q <= FINISH;
            end else begin
              idx_q     <= '0;
              desc_re_q <= 1'b1;
              addr_q    <= word_addr(4'd0, 2'd0);
              state_q   <= FETCH;
            end
          end
        end
        FETCH: begin
          k_q       <= '0;
          w_en_q    <= 1'b1;
          wsel_q    <= 2'd0;
          desc_re_q <= 1'b1;
          addr_q    <= word_addr(idx_q, 2'd1);
          state_q   <= LOAD;
        end
        LOAD: begin
          if (k_q == 2'd3) begin
            w_en_q    <= 1'b0;
            wsel_q    <= '0;
            opcfg_q   <= load_wdata;
            state_q   <= WAIT_DONE;
          end else begin
            k_q       <= k_q + 2'd1;
            wsel_q    <= k_q + 2'd1;
            desc_re_q <= (k_q != 2'd2);
            addr_q    <= (k_q != 2'd2) ? word_addr(idx_q, k_q + 2'd2) : '0;
          end
        end
        WAIT_DONE: begin
          if (bus.dla_done) begin
            w_en_q  <= 1'b1;
            wsel_q  <= 2'd3;
            wdata_q <= {opcfg_q[31:1], 1'b0};
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          w_en_q  <= 1'b0;
          wsel_q  <= '0;
          wdata_q <= '0;
          state_q <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (!bus.dla_done) begin
            if (last_layer) begin
              state_q <= FINISH;
            end else begin
              idx_q     <= idx_q + 4'd1;
              desc_re_q <= 1'b1;
              addr_q    <= word_addr(idx_q + 4'd1, 2'd0);
              state_q   <= FETCH;
            end
          end
        end
        FINISH: begin
          all_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.all_done       = all_done_q;
  assign bus.layer_idx      = idx_q;
  assign bus.desc_re        = desc_re_q;
  assign bus.desc_addr      = addr_q;
  assign bus.ctrl_reg_w_en  = w_en_q;
  assign bus.ctrl_reg_wsel  = wsel_q;
  assign bus.ctrl_reg_wdata = (state_q == LOAD) ? load_wdata : wdata_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a descriptor SRAM model and an accelerator
// model that raises dla_done 20 cycles after op_config is written with bit0 set.
module tb_layer_sequencer;

  localparam int DONE_DLY = 20;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  layer_sequencer_if #(.DESC_ADDR_BITS(6)) bus ();

  layer_sequencer #(.NUM_LAYERS_MAX(16), .DESC_ADDR_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [64];
  always @(posedge clk) if (bus.desc_re) bus.desc_rdata <= mem[bus.desc_addr];

  logic        acc_run;
  int unsigned acc_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dla_done <= 1'b0;
      acc_run      <= 1'b0;
      acc_cnt      <= 0;
    end else if (bus.ctrl_reg_w_en && bus.ctrl_reg_wsel == 2'd3) begin
      if (bus.ctrl_reg_wdata[0]) begin
        acc_run <= 1'b1;
        acc_cnt <= 0;
      end else begin
        bus.dla_done <= 1'b0;
      end
    end else if (acc_run) begin
      if (acc_cnt == DONE_DLY - 2) begin
        bus.dla_done <= 1'b1;
        acc_run      <= 1'b0;
      end
      acc_cnt <= acc_cnt + 1;
    end
  end

  logic [1:0]  wr_sel  [$];
  logic [31:0] wr_data [$];
  int unsigned wr_cyc  [$];
  logic [3:0]  wr_idx  [$];
  logic [5:0]  rd_addr [$];
  int unsigned rd_cyc  [$];
  int unsigned done_cnt, done_cyc, busy_cyc;

  always @(negedge clk) begin
    if (bus.ctrl_reg_w_en) begin
      wr_sel.push_back(bus.ctrl_reg_wsel);
      wr_data.push_back(bus.ctrl_reg_wdata);
      wr_cyc.push_back(cyc);
      wr_idx.push_back(bus.layer_idx);
    end
    if (bus.desc_re) begin
      rd_addr.push_back(bus.desc_addr);
      rd_cyc.push_back(cyc);
    end
    if (bus.all_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (bus.busy) busy_cyc = busy_cyc + 1;
  end

  task automatic clear_logs;
    wr_sel.delete(); wr_data.delete(); wr_cyc.delete(); wr_idx.delete();
    rd_addr.delete(); rd_cyc.delete();
    done_cnt = 0; done_cyc = 0; busy_cyc = 0;
  endtask

  task automatic kick(input logic [4:0] n, output int unsigned s0);
    @(negedge clk);
    bus.num_layers = n;
    bus.start      = 1'b1;
    s0             = cyc;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic wait_run(input int unsigned limit);
    int unsigned i = 0;
    while (done_cnt == 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | (i << 4);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_layers = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.all_done !== 1'b0) begin n_bad++; $display("FAIL reset.all_done: got %b expected 0", bus.all_done); end
    n_cmp++; if (bus.layer_idx !== 4'd0) begin n_bad++; $display("FAIL reset.layer_idx: got %0d expected 0", bus.layer_idx); end
    n_cmp++; if (bus.desc_re !== 1'b0) begin n_bad++; $display("FAIL reset.desc_re: got %b expected 0", bus.desc_re); end
    n_cmp++; if (bus.desc_addr !== 6'd0) begin n_bad++; $display("FAIL reset.desc_addr: got %0d expected 0", bus.desc_addr); end
    n_cmp++; if (bus.ctrl_reg_w_en !== 1'b0) begin n_bad++; $display("FAIL reset.w_en: got %b expected 0", bus.ctrl_reg_w_en); end
    n_cmp++; if (bus.ctrl_reg_wsel !== 2'd0) begin n_bad++; $display("FAIL reset.wsel: got %0d expected 0", bus.ctrl_reg_wsel); end
    n_cmp++; if (bus.ctrl_reg_wdata !== 32'd0) begin n_bad++; $display("FAIL reset.wdata: got %h expected 0", bus.ctrl_reg_wdata); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_layer;
    int unsigned s0;
    logic [31:0] exp_d [5];
    int unsigned exp_c [5];
    logic [1:0]  exp_s [5];
    mem[0] = 32'h0000_2249; mem[1] = 32'h0550_0000;
    mem[2] = 32'h0000_2222; mem[3] = 32'h0000_0400;
    exp_d = '{32'h0000_2249, 32'h0550_0000, 32'h0000_2222, 32'h0000_0401, 32'h0000_0400};
    exp_c = '{2, 3, 4, 5, 26};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    clear_logs();
    kick(5'd1, s0);
    wait_run(200);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single.done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (done_cyc - s0 !== 29) begin n_bad++; $display("FAIL single.done_cycle: got %0d expected 29", done_cyc - s0); end
    n_cmp++; if (busy_cyc !== 28) begin n_bad++; $display("FAIL single.busy_cycles: got %0d expected 28", busy_cyc); end
    n_cmp++; if (wr_sel.size() !== 5) begin n_bad++; $display("FAIL single.write_count: got %0d expected 5", wr_sel.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < wr_sel.size()) begin
        n_cmp++; if (wr_sel[k] !== exp_s[k]) begin n_bad++; $display("FAIL single.wsel[%0d]: got %0d expected %0d", k, wr_sel[k], exp_s[k]); end
        n_cmp++; if (wr_data[k] !== exp_d[k]) begin n_bad++; $display("FAIL single.wdata[%0d]: got %h expected %h", k, wr_data[k], exp_d[k]); end
        n_cmp++; if (wr_cyc[k] - s0 !== exp_c[k]) begin n_bad++; $display("FAIL single.wcycle[%0d]: got %0d expected %0d", k, wr_cyc[k] - s0, exp_c[k]); end
      end
    end
    n_cmp++; if (rd_addr.size() !== 4) begin n_bad++; $display("FAIL single.read_count: got %0d expected 4", rd_addr.size()); end
    for (int a = 0; a < 4; a++) begin
      if (a < rd_addr.size()) begin
        n_cmp++; if (rd_addr[a] !== 6'(a)) begin n_bad++; $display("FAIL single.raddr[%0d]: got %0d expected %0d", a, rd_addr[a], a); end
        n_cmp++; if (rd_cyc[a] - s0 !== a + 1) begin n_bad++; $display("FAIL single.rcycle[%0d]: got %0d expected %0d", a, rd_cyc[a] - s0, a + 1); end
      end
    end
  endtask

  task automatic test_three_layers;
    int unsigned s0, j;
    logic [31:0] exp_d;
    fill_mem();
    clear_logs();
    kick(5'd3, s0);
    wait_run(400);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL three.done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (done_cyc - s0 !== 83) begin n_bad++; $display("FAIL three.done_cycle: got %0d expected 83", done_cyc - s0); end
    n_cmp++; if (busy_cyc !== 82) begin n_bad++; $display("FAIL three.busy_cycles: got %0d expected 82", busy_cyc); end
    n_cmp++; if (wr_sel.size() !== 15) begin n_bad++; $display("FAIL three.write_count: got %0d expected 15", wr_sel.size()); end
    n_cmp++; if (rd_addr.size() !== 12) begin n_bad++; $display("FAIL three.read_count: got %0d expected 12", rd_addr.size()); end
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 5; k++) begin
        j = 5 * l + k;
        exp_d = (k < 3) ? mem[4*l+k] : (k == 3) ? (mem[4*l+3] | 32'd1) : mem[4*l+3];
        if (j < wr_sel.size()) begin
          n_cmp++; if (wr_sel[j] !== ((k == 4) ? 2'd3 : 2'(k))) begin n_bad++; $display("FAIL three.wsel[%0d]: got %0d expected %0d", j, wr_sel[j], (k == 4) ? 3 : k); end
          n_cmp++; if (wr_data[j] !== exp_d) begin n_bad++; $display("FAIL three.wdata[%0d]: got %h expected %h", j, wr_data[j], exp_d); end
          n_cmp++; if (wr_idx[j] !== 4'(l)) begin n_bad++; $display("FAIL three.layer_idx[%0d]: got %0d expected %0d", j, wr_idx[j], l); end
          n_cmp++; if (wr_cyc[j] - s0 !== 27 * l + 2 + k + ((k == 4) ? 20 : 0)) begin n_bad++; $display("FAIL three.wcycle[%0d]: got %0d expected %0d", j, wr_cyc[j] - s0, 27 * l + 2 + k + ((k == 4) ? 20 : 0)); end
        end
      end
    end
    for (int a = 0; a < 12; a++) begin
      if (a < rd_addr.size()) begin
        n_cmp++; if (rd_addr[a] !== 6'(a)) begin n_bad++; $display("FAIL three.raddr[%0d]: got %0d expected %0d", a, rd_addr[a], a); end
      end
    end
  endtask

  task automatic test_zero_layers;
    int unsigned s0;
    clear_logs();
    kick(5'd0, s0);
    wait_run(20);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero.done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (done_cyc - s0 !== 2) begin n_bad++; $display("FAIL zero.done_cycle: got %0d expected 2", done_cyc - s0); end
    n_cmp++; if (busy_cyc !== 1) begin n_bad++; $display("FAIL zero.busy_cycles: got %0d expected 1", busy_cyc); end
    n_cmp++; if (rd_addr.size() !== 0) begin n_bad++; $display("FAIL zero.read_count: got %0d expected 0", rd_addr.size()); end
    n_cmp++; if (wr_sel.size() !== 0) begin n_bad++; $display("FAIL zero.write_count: got %0d expected 0", wr_sel.size()); end
  endtask

  task automatic test_clamp;
    int unsigned s0;
    fill_mem();
    clear_logs();
    kick(5'd20, s0);
    wait_run(1000);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL clamp.done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (done_cyc - s0 !== 434) begin n_bad++; $display("FAIL clamp.done_cycle: got %0d expected 434", done_cyc - s0); end
    n_cmp++; if (wr_sel.size() !== 80) begin n_bad++; $display("FAIL clamp.write_count: got %0d expected 80", wr_sel.size()); end
    n_cmp++; if (rd_addr.size() !== 64) begin n_bad++; $display("FAIL clamp.read_count: got %0d expected 64", rd_addr.size()); end
    if (rd_addr.size() > 0) begin
      n_cmp++; if (rd_addr[rd_addr.size()-1] !== 6'd63) begin n_bad++; $display("FAIL clamp.last_raddr: got %0d expected 63", rd_addr[rd_addr.size()-1]); end
    end
    if (wr_sel.size() > 0) begin
      n_cmp++; if (wr_idx[wr_idx.size()-1] !== 4'd15) begin n_bad++; $display("FAIL clamp.last_idx: got %0d expected 15", wr_idx[wr_idx.size()-1]); end
      n_cmp++; if (wr_data[wr_data.size()-1] !== 32'hC000_03F0) begin n_bad++; $display("FAIL clamp.last_clear: got %h expected c00003f0", wr_data[wr_data.size()-1]); end
    end
    n_cmp++; if (bus.layer_idx !== 4'd15) begin n_bad++; $display("FAIL clamp.idx_hold: got %0d expected 15", bus.layer_idx); end
  endtask

  task automatic test_busy_start;
    int unsigned s0;
    fill_mem();
    clear_logs();
    kick(5'd1, s0);
    repeat (9) @(negedge clk);
    bus.num_layers = 5'd3; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (13) @(negedge clk);
    n_cmp++; if (bus.all_done !== 1'b1) begin n_bad++; $display("FAIL busy_start.all_done_cycle: got %b expected 1", bus.all_done); end
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_start.done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (wr_sel.size() !== 5) begin n_bad++; $display("FAIL busy_start.write_count: got %0d expected 5", wr_sel.size()); end
    n_cmp++; if (rd_addr.size() !== 4) begin n_bad++; $display("FAIL busy_start.read_count: got %0d expected 4", rd_addr.size()); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_start.busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_load;
    int unsigned s0, nwr;
    fill_mem();
    clear_logs();
    kick(5'd1, s0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    nwr = wr_sel.size();
    n_cmp++; if (bus.ctrl_reg_w_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid.w_en: got %b expected 0", bus.ctrl_reg_w_en); end
    n_cmp++; if (bus.ctrl_reg_wsel !== 2'd0) begin n_bad++; $display("FAIL rst_mid.wsel: got %0d expected 0", bus.ctrl_reg_wsel); end
    n_cmp++; if (bus.ctrl_reg_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_mid.wdata: got %h expected 0", bus.ctrl_reg_wdata); end
    n_cmp++; if (bus.desc_re !== 1'b0) begin n_bad++; $display("FAIL rst_mid.desc_re: got %b expected 0", bus.desc_re); end
    n_cmp++; if (bus.desc_addr !== 6'd0) begin n_bad++; $display("FAIL rst_mid.desc_addr: got %0d expected 0", bus.desc_addr); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid.busy: got %b expected 0", bus.busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid.busy_after: got %b expected 0", bus.busy); end
    n_cmp++; if (wr_sel.size() !== nwr) begin n_bad++; $display("FAIL rst_mid.writes_after: got %0d expected %0d", wr_sel.size(), nwr); end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rst_mid.done_cnt: got %0d expected 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_three_layers();
    test_zero_layers();
    test_busy_start();
    test_clamp();
    test_reset_mid_load();
    test_zero_layers();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t expected bench to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Host-side sequencer that sits directly upstream of the DLA top's control-register port. It fetches per-layer descriptors (mapping_param, shape_param1, shape_param2, op_config) from a descriptor SRAM and writes them into the accelerator's control registers. It then waits for `dla_done`, clears the start bit, waits for the accelerator to return to idle, and advances to the next layer until `num_layers` layers have run.

## Interface
Parameters:
- NUM_LAYERS_MAX, 16, maximum layers per run; `num_layers` above this is clamped.
- DESC_ADDR_BITS, 6, descriptor SRAM word-address width; must satisfy 2^DESC_ADDR_BITS ≥ 4*NUM_LAYERS_MAX.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle run request; ignored while `busy`=1.
- num_layers  in  5  layers to run; sampled when `start` is accepted.
- busy  out  1  high from the cycle after an accepted `start` until `all_done`.
- all_done  out  1  one-cycle pulse when the run completes.
- layer_idx  out  4  index of the layer currently being loaded or run.
- desc_re  out  1  descriptor SRAM read enable.
- desc_addr  out  DESC_ADDR_BITS  word address; layer L, word k is at 4*L+k.
- desc_rdata  in  32  read data, valid exactly one cycle after `desc_re`.
- ctrl_reg_w_en  out  1  control-register write strobe.
- ctrl_reg_wsel  out  2  register select: 0 mapping_param, 1 shape_param1, 2 shape_param2, 3 op_config.
- ctrl_reg_wdata  out  32  register write data.
- dla_done  in  1  accelerator done level; high while the accelerator is in its done state.

## Operation
- States: IDLE, FETCH, LOAD, WAIT_DONE, CLEAR, WAIT_IDLE, FINISH.
- IDLE: on `start`=1, latch n = min(num_layers, NUM_LAYERS_MAX).
  - If n=0, go to FINISH.
  - Otherwise set layer_idx=0 and go to FETCH.
- FETCH (1 cycle): desc_re=1, desc_addr=4*layer_idx. Set word counter k=0 and go to LOAD.
- LOAD (4 cycles, k=0..3):
  - Drive ctrl_reg_w_en=1, ctrl_reg_wsel=k, ctrl_reg_wdata=desc_rdata.
  - While k<3, also drive desc_re=1 and desc_addr=4*layer_idx+k+1, so fetch and write overlap.
  - At k=3, force wdata[0]=1 and store the written op_config value internally.
  - After k=3, go to WAIT_DONE.
  - op_config is always the last register written, because writing it starts the accelerator.
- WAIT_DONE: hold with no writes until dla_done=1, then go to CLEAR.
- CLEAR (1 cycle): ctrl_reg_w_en=1, wsel=3, wdata = stored op_config with bit0=0. Then go to WAIT_IDLE.
- WAIT_IDLE: wait for dla_done=0.
  - If layer_idx+1 = n, go to FINISH.
  - Otherwise increment layer_idx and go to FETCH.
- FINISH (1 cycle): all_done=1, then go to IDLE. busy=0 in IDLE; layer_idx holds its last value.
- Arithmetic: desc_addr = {layer_idx, k[1:0]}, zero-extended or truncated to DESC_ADDR_BITS. No wrap occurs within a legal run.
- Outputs are registered or decoded from state only. They carry no combinational path from `dla_done`; `desc_rdata` passes only to `ctrl_reg_wdata`.

## Timing
- Reset values: busy=0, all_done=0, layer_idx=0, desc_re=0, desc_addr=0, ctrl_reg_w_en=0, ctrl_reg_wsel=0, ctrl_reg_wdata=0. State returns to IDLE.
- Reset asserted mid-run aborts immediately and produces no further writes. The host must also reset the accelerator.
- Cycle 0: `start` is sampled. Cycle 1: FETCH. Cycles 2-5: LOAD with wsel 0,1,2,3. WAIT_DONE begins at cycle 6.
- dla_done sampled high at cycle d: CLEAR write occurs in cycle d+1.
- If dla_done is already high on entry to WAIT_DONE (stale), the sequencer still proceeds to CLEAR. The host must not start with the accelerator in its done state.
- Per-layer overhead outside accelerator run time: 5 load cycles + 1 clear cycle + idle wait (≥1 cycle).
- `start` during busy: no effect, including when it coincides with all_done.
- `start` in the same cycle as the FINISH→IDLE transition: ignored. `start` is accepted only while in IDLE.

## Test plan
- Single layer:
  - Stimulus: descriptors {0x0000_2249, 0x0550_0000, 0x0000_2222, 0x0000_0400}, n=1; accelerator model raises dla_done 20 cycles after the op_config write.
  - Required: writes wsel 0..3 in cycles 2-5, op_config data 0x0000_0401; CLEAR writes 0x0000_0400; one all_done pulse.
- Three layers:
  - Stimulus: n=3, distinct descriptors per layer.
  - Required: desc_addr sequences 0-3, 4-7, 8-11; layer_idx steps 0→1→2; exactly 15 ctrl writes; one all_done pulse.
- Zero layers:
  - Stimulus: num_layers=0.
  - Required: all_done in cycle 2, no desc_re and no ctrl_reg_w_en, busy pulses 1 cycle.
- Clamp:
  - Stimulus: num_layers=20.
  - Required: exactly 16 layers run; the last desc_addr is 63.
- Busy start:
  - Stimulus: `start` pulses during WAIT_DONE.
  - Required: no state change and no extra writes.
- Reset mid-LOAD:
  - Stimulus: rst=0 at cycle 3.
  - Required: all outputs 0 in the same cycle (asynchronous); after release, IDLE with busy=0.
